// File: rtl/mdu_dec.sv
// Multiply/divide unit for the MIPS HI/LO group, with its own R-type funct decoder.
// Iterative shift-add multiply and restoring divide retire one bit per clock.
module mdu_dec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             mdu_sel,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   prod_reg;
    logic [WIDTH-1:0]     opnd_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 sign_a_reg, sign_b_reg, op_div_reg;

    logic is_mult, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo, is_signed;
    logic md_cmd, mdu_cmd, running, last, accept, finish;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        is_mult = 1'b0;
        is_div  = 1'b0;
        is_mfhi = 1'b0;
        is_mflo = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        if (en && alu_op == 2'b10) begin
            case (funct)
                6'b011000, 6'b011001: is_mult = 1'b1;
                6'b011010, 6'b011011: is_div  = 1'b1;
                6'b010000:            is_mfhi = 1'b1;
                6'b010010:            is_mflo = 1'b1;
                6'b010001:            is_mthi = 1'b1;
                6'b010011:            is_mtlo = 1'b1;
                default: ;
            endcase
        end
    end

    // Even funct codes of the mult/div group are the signed variants.
    assign is_signed = ~funct[0];
    assign md_cmd    = is_mult | is_div;
    assign mdu_cmd   = md_cmd | is_mfhi | is_mflo | is_mthi | is_mtlo;
    assign running   = (state_reg == RUN);
    assign last      = (cnt_reg == CW'(WIDTH - 1));
    assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (md_cmd) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = running;
        done    = (state_reg == DONE);
        stall   = running & mdu_cmd;
        mdu_sel = ~running & (is_mfhi | is_mflo);
        result  = '0;
        if (!running && is_mfhi)
            result = hi_reg;
        else if (!running && is_mflo)
            result = lo_reg;
    end

    // One iteration: prod_reg holds {partial, multiplier} or {remainder, quotient}.
    logic [WIDTH:0]       mul_sum, div_sh;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_fit;
    logic [2*WIDTH-1:0]   mul_step, div_step, step;

    assign mul_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    assign mul_step = prod_reg[0] ? {mul_sum, prod_reg[WIDTH-1:1]}
                                  : {1'b0, prod_reg[2*WIDTH-1:1]};
    assign div_sh   = {prod_reg[2*WIDTH-1:WIDTH], prod_reg[WIDTH-1]};
    assign div_diff = div_sh[WIDTH-1:0] - opnd_reg;
    assign div_fit  = (div_sh >= {1'b0, opnd_reg});
    assign div_step = div_fit ? {div_diff, prod_reg[WIDTH-2:0], 1'b1}
                              : {div_sh[WIDTH-1:0], prod_reg[WIDTH-2:0], 1'b0};
    assign step     = op_div_reg ? div_step : mul_step;

    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    // A zero divisor leaves all-ones quotient and |a| as remainder, so only the
    // quotient sign fix must be suppressed; the remainder fix restores raw a.
    always_comb begin
        mul_fix = (sign_a_reg ^ sign_b_reg) ? -step : step;
        quo     = step[WIDTH-1:0];
        rem     = step[2*WIDTH-1:WIDTH];
        if (op_div_reg) begin
            fin_hi = sign_a_reg ? -rem : rem;
            if (opnd_reg == '0)
                fin_lo = '1;
            else
                fin_lo = (sign_a_reg ^ sign_b_reg) ? -quo : quo;
        end else begin
            fin_hi = mul_fix[2*WIDTH-1:WIDTH];
            fin_lo = mul_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_reg   <= '0;
            opnd_reg   <= '0;
            cnt_reg    <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            op_div_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            if (accept) begin
                sign_a_reg <= is_signed & a[WIDTH-1];
                sign_b_reg <= is_signed & b[WIDTH-1];
                op_div_reg <= is_div;
                cnt_reg    <= '0;
                prod_reg   <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                opnd_reg   <= is_div ? abs_b : abs_a;
            end else if (running) begin
                prod_reg <= step;
                cnt_reg  <= cnt_reg + CW'(1);
            end

            if (finish) begin
                hi_reg <= fin_hi;
                lo_reg <= fin_lo;
            end else if (!running) begin
                if (is_mthi)
                    hi_reg <= a;
                if (is_mtlo)
                    lo_reg <= a;
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: tb/tb_mdu_dec.sv
// Randomized and directed bench for mdu_dec (WIDTH=32) against a cycle-count
// reference model that computes HI/LO with plain 64-bit arithmetic.
module tb_mdu_dec;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    alu_op = 2'b00;
    logic [5:0]    funct = 6'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          stall, busy, done, mdu_sel;
    logic [W-1:0]  result, hi, lo;

    int compared = 0;
    int mismatched = 0;

    mdu_dec #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .funct(funct),
        .a(a), .b(b), .stall(stall), .busy(busy), .done(done),
        .mdu_sel(mdu_sel), .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic for the mult/div group.
    function automatic void model_op(input logic [5:0] f, input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     output logic [W-1:0] h, output logic [W-1:0] l);
        logic [63:0] p;
        longint      sq, sr;
        h = '0;
        l = '0;
        case (f)
            6'b011000: begin
                p = longint'($signed(x)) * longint'($signed(y));
                h = p[63:32];
                l = p[31:0];
            end
            6'b011001: begin
                p = {32'b0, x} * {32'b0, y};
                h = p[63:32];
                l = p[31:0];
            end
            6'b011010: begin
                if (y == 0) begin
                    l = '1;
                    h = x;
                end else begin
                    sq = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    l = sq[31:0];
                    h = sr[31:0];
                end
            end
            6'b011011: begin
                if (y == 0) begin
                    l = '1;
                    h = x;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    // Model state: HI/LO, remaining busy cycles, pending result, done flag.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;
    bit           m_done = 0;

    always @(negedge clk) begin
        logic          v, is_md, is_mfh, is_mfl, is_mth, is_mtl, any, nd;
        logic [W-1:0]  e_res;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_hi", hi, 0);
            chk("rst_lo", lo, 0);
        end else begin
            v      = en && (alu_op == 2'b10);
            is_md  = v && (funct inside {6'b011000, 6'b011001, 6'b011010, 6'b011011});
            is_mfh = v && (funct == 6'b010000);
            is_mfl = v && (funct == 6'b010010);
            is_mth = v && (funct == 6'b010001);
            is_mtl = v && (funct == 6'b010011);
            any    = is_md | is_mfh | is_mfl | is_mth | is_mtl;
            e_res  = (m_left == 0 && is_mfh) ? m_hi : (m_left == 0 && is_mfl) ? m_lo : '0;
            chk("stall", stall, (m_left > 0) && any);
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            chk("mdu_sel", mdu_sel, (m_left == 0) && (is_mfh || is_mfl));
            chk("result", result, e_res);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            nd = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    nd = 1;
                end
            end else begin
                if (is_md) begin
                    model_op(funct, a, b, p_hi, p_lo);
                    m_left = W;
                end
                if (is_mth) m_hi = a;
                if (is_mtl) m_lo = a;
            end
            m_done = nd;
        end
    end

    task automatic set_in(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        en = 1'b1; alu_op = 2'b10; funct = f; a = x; b = y;
    endtask

    task automatic clr_in();
        en = 1'b0; alu_op = 2'b00; funct = 6'b0;
    endtask

    // Present one command for a single cycle; accept edge is the second posedge.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk); #1;
        set_in(f, x, y);
        @(posedge clk); #1;
        clr_in();
    endtask

    // Returns at the negedge of the done cycle; nb counts busy cycles seen.
    task automatic wait_done(output int nb);
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) nb++;
        end
        chk("done_seen", done, 1);
    endtask

    logic [5:0]   ftab [10];
    logic [W-1:0] spec [6];

    initial begin
        int nb;
        ftab = '{6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000,
                 6'b010010, 6'b010001, 6'b010011, 6'b100000, 6'b011100};
        spec = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h2};

        repeat (2) @(posedge clk);
        #1;
        chk("init_stall", stall, 0);
        chk("init_sel", mdu_sel, 0);
        reset = 1'b0;

        issue(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(nb);
        chk("multu_busy_cycles", nb, 32);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        issue(6'b011000, 32'hFFFFFFFD, 32'h00000007);
        wait_done(nb);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        @(posedge clk); #1;
        set_in(6'b010010, 32'h0, 32'h0);
        #1;
        chk("mflo_sel", mdu_sel, 1);
        chk("mflo_result", result, 32'hFFFFFFEB);
        chk("mflo_stall", stall, 0);
        @(posedge clk); #1;
        clr_in();

        issue(6'b011010, 32'hFFFFFFF9, 32'h00000002);
        wait_done(nb);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        issue(6'b011010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(nb);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h00000000);

        issue(6'b011011, 32'h00001234, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        set_in(6'b010000, 32'h0, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            chk("mfhi_stall_run", stall, 1);
        end
        chk("div0_done_seen", done, 1);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("mfhi_after_stall", stall, 0);
        chk("mfhi_result", result, 32'h00001234);
        @(posedge clk); #1;
        clr_in();

        @(posedge clk); #1;
        set_in(6'b010001, 32'hDEADBEEF, 32'h0);
        #1;
        chk("mthi_stall", stall, 0);
        @(posedge clk); #1;
        set_in(6'b010011, 32'h0000CAFE, 32'h0);
        #1;
        chk("mtlo_stall", stall, 0);
        @(posedge clk); #1;
        clr_in();
        #1;
        chk("mt_hi", hi, 32'hDEADBEEF);
        chk("mt_lo", lo, 32'h0000CAFE);

        issue(6'b011001, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_hi", hi, 0);
        chk("rstmid_lo", lo, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        issue(6'b011000, 32'd5, 32'd6);
        wait_done(nb);
        chk("after_rst_hi", hi, 0);
        chk("after_rst_lo", lo, 32'd30);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            en     = ($urandom_range(0, 9) < 8);
            alu_op = ($urandom_range(0, 9) < 8) ? 2'b10 : 2'($urandom_range(0, 3));
            funct  = ftab[$urandom_range(0, 9)];
            a      = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)] : $urandom;
            b      = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)] : $urandom;
        end
        @(posedge clk); #1;
        clr_in();
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
